// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
package hazard_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } hazard_state_t;

  localparam int unsigned MULDIV_LAT_MAX = 63;

  // Width needed to hold a count in 0..lat.
  function automatic int cnt_width(input int unsigned lat);
    return $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/muldiv_busy_timer.sv
// MUL/DIV occupancy timer: tracks the HI/LO result window after issue from EX.
// busy/done/protocol_err are registered so an async reset clears them at once.
module muldiv_busy_timer
  import hazard_pkg::*;
#(
  parameter int unsigned MULDIV_LATENCY = 5
) (
  input  logic clock,
  input  logic reset,
  input  logic muldiv_issue,
  output logic busy,
  output logic done,
  output logic protocol_err
);

  // Out-of-range latencies are pinned into 1..MULDIV_LAT_MAX.
  localparam int unsigned LAT_EFF = (MULDIV_LATENCY < 1) ? 1 :
                                    (MULDIV_LATENCY > MULDIV_LAT_MAX) ? MULDIV_LAT_MAX :
                                    MULDIV_LATENCY;
  localparam int CW = cnt_width(LAT_EFF);
  localparam logic [CW-1:0] RELOAD = CW'(LAT_EFF - 1);
  localparam logic RELOAD_DONE = (LAT_EFF == 1);

  hazard_state_t   state;
  logic [CW-1:0]   cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (muldiv_issue) begin
            state <= BUSY;
            cnt   <= RELOAD;
            busy  <= 1'b1;
            done  <= RELOAD_DONE;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            // Done cycle: a new issue is legal here and restarts the window.
            if (muldiv_issue) begin
              cnt  <= RELOAD;
              done <= RELOAD_DONE;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b0;
            end
          end else begin
            cnt  <= cnt - CW'(1);
            done <= (cnt == CW'(1));
            if (muldiv_issue) protocol_err <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/hazard_sequencer.sv
// Stall/flush scheduler for the 5-stage pipeline: merges forwarding stalls, branch redirects
// and MUL/DIV occupancy. Optional perf counters are built only when HAZARD_PERF_EN is defined.
module hazard_sequencer
  import hazard_pkg::*;
#(
  parameter int unsigned MULDIV_LATENCY = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fwd_stall_rs,
  input  logic        fwd_stall_rt,
  input  logic        branch_taken,
  input  logic        hilo_use,
  input  logic        muldiv_issue,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        muldiv_busy,
  output logic        muldiv_done,
  output logic        protocol_err,
  output logic [31:0] stall_count,
  output logic [31:0] flush_count
);

  logic stall;

  muldiv_busy_timer #(
    .MULDIV_LATENCY(MULDIV_LATENCY)
  ) u_timer (
    .clock        (clock),
    .reset        (reset),
    .muldiv_issue (muldiv_issue),
    .busy         (muldiv_busy),
    .done         (muldiv_done),
    .protocol_err (protocol_err)
  );

  // HI/LO becomes readable in the done cycle, so hilo_use only stalls before it.
  always_comb begin
    stall       = fwd_stall_rs | fwd_stall_rt | (hilo_use & muldiv_busy & ~muldiv_done);
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (stall) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
    end else if (branch_taken) begin
      if_id_flush = 1'b1;
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall && (stall_count != 32'hFFFF_FFFF)) stall_count <= stall_count + 32'd1;
      if (if_id_flush && (flush_count != 32'hFFFF_FFFF)) flush_count <= flush_count + 32'd1;
    end
  end
`else
  assign stall_count = 32'h0;
  assign flush_count = 32'h0;
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// Self-checking bench for hazard_sequencer: directed scenarios plus randomized traffic
// compared against a cycle-count reference model.
module tb_hazard_sequencer;

  localparam int LAT = 5;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        rs = 1'b0, rt = 1'b0, br = 1'b0, hilo = 1'b0, issue = 1'b0;
  logic        pc_write, if_id_write, if_id_flush, id_ex_flush;
  logic        muldiv_busy, muldiv_done, protocol_err;
  logic [31:0] stall_count, flush_count;

  int     n_checks = 0;
  int     n_fail   = 0;

  // Reference model: pend = cycles of HI/LO occupancy left, including the current one.
  int     pend = 0;
  bit     m_err = 0;
  longint m_sc = 0;
  longint m_fc = 0;

  hazard_sequencer #(.MULDIV_LATENCY(LAT)) dut (
    .clock        (clock),
    .reset        (reset),
    .fwd_stall_rs (rs),
    .fwd_stall_rt (rt),
    .branch_taken (br),
    .hilo_use     (hilo),
    .muldiv_issue (issue),
    .pc_write     (pc_write),
    .if_id_write  (if_id_write),
    .if_id_flush  (if_id_flush),
    .id_ex_flush  (id_ex_flush),
    .muldiv_busy  (muldiv_busy),
    .muldiv_done  (muldiv_done),
    .protocol_err (protocol_err),
    .stall_count  (stall_count),
    .flush_count  (flush_count)
  );

  always #5 clock = ~clock;

  function automatic bit e_busy();
    return pend > 0;
  endfunction

  function automatic bit e_done();
    return pend == 1;
  endfunction

  function automatic bit e_stall();
    return rs || rt || (hilo && e_busy() && !e_done());
  endfunction

  // {pc_write, if_id_write, if_id_flush, id_ex_flush}
  function automatic logic [3:0] e_ctrl();
    if (e_stall()) return 4'b0001;
    if (br) return 4'b1110;
    return 4'b1100;
  endfunction

  task automatic tick();
    @(posedge clock);
    if (!reset) begin
      if (e_stall()) begin
        if (m_sc < 64'hFFFF_FFFF) m_sc++;
      end else if (br) begin
        if (m_fc < 64'hFFFF_FFFF) m_fc++;
      end
      if (issue) begin
        if (pend <= 1) pend = LAT;
        else begin
          m_err = 1'b1;
          pend--;
        end
      end else if (pend > 0) begin
        pend--;
      end
    end
    #1;
  endtask

  task automatic model_clear();
    pend = 0;
    m_err = 1'b0;
    m_sc = 0;
    m_fc = 0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    {rs, rt, br, hilo, issue} = '0;
    model_clear();
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    {rs, rt, br, hilo, issue} = '0;
    #3;
    n_checks++;
    if ({pc_write, if_id_write, if_id_flush, id_ex_flush} !== 4'b1100) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 1100", {pc_write, if_id_write, if_id_flush, id_ex_flush});
    end
    n_checks++;
    if ({muldiv_busy, muldiv_done, protocol_err} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_status: got %b want 000", {muldiv_busy, muldiv_done, protocol_err});
    end
    n_checks++;
    if ({stall_count, flush_count} !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_counts: got %0d/%0d want 0/0", stall_count, flush_count);
    end
    apply_reset();
  endtask

  task automatic test_fwd_stall();
    rs = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #3;
      n_checks++;
      if ({pc_write, if_id_write, if_id_flush, id_ex_flush} !== 4'b0001) begin
        n_fail++;
        $display("FAIL fwd_stall cycle %0d: got %b want 0001", i,
                 {pc_write, if_id_write, if_id_flush, id_ex_flush});
      end
      tick();
    end
    rs = 1'b0;
    #3;
    n_checks++;
    if ({pc_write, if_id_write, if_id_flush, id_ex_flush} !== 4'b1100) begin
      n_fail++;
      $display("FAIL fwd_stall_release: got %b want 1100", {pc_write, if_id_write, if_id_flush, id_ex_flush});
    end
    tick();
  endtask

  task automatic test_branch();
    br = 1'b1;
    #3;
    n_checks++;
    if ({pc_write, if_id_write, if_id_flush, id_ex_flush} !== 4'b1110) begin
      n_fail++;
      $display("FAIL branch_flush: got %b want 1110", {pc_write, if_id_write, if_id_flush, id_ex_flush});
    end
    tick();
    rt = 1'b1;
    #3;
    n_checks++;
    if ({pc_write, if_id_write, if_id_flush, id_ex_flush} !== 4'b0001) begin
      n_fail++;
      $display("FAIL branch_under_stall: got %b want 0001", {pc_write, if_id_write, if_id_flush, id_ex_flush});
    end
    tick();
    br = 1'b0;
    rt = 1'b0;
  endtask

  task automatic test_muldiv();
    apply_reset();
    issue = 1'b1;
    tick();
    issue = 1'b0;
    hilo = 1'b1;
    for (int k = 1; k <= LAT + 1; k++) begin
      #3;
      n_checks++;
      if ({muldiv_busy, muldiv_done, pc_write} !== {1'(k <= LAT), 1'(k == LAT), 1'(k >= LAT)}) begin
        n_fail++;
        $display("FAIL muldiv t%0d busy/done/pc_write: got %b want %b", k,
                 {muldiv_busy, muldiv_done, pc_write}, {1'(k <= LAT), 1'(k == LAT), 1'(k >= LAT)});
      end
      tick();
    end
    hilo = 1'b0;
    n_checks++;
    if (protocol_err !== 1'b0) begin
      n_fail++;
      $display("FAIL muldiv_no_err: got %b want 0", protocol_err);
    end
  endtask

  task automatic test_protocol();
    apply_reset();
    issue = 1'b1;
    tick();
    issue = 1'b0;
    tick();
    tick();
    issue = 1'b1;
    tick();
    issue = 1'b0;
    #3;
    n_checks++;
    if ({protocol_err, muldiv_busy, muldiv_done} !== 3'b110) begin
      n_fail++;
      $display("FAIL protocol_ignored_issue: got %b want 110", {protocol_err, muldiv_busy, muldiv_done});
    end
    tick();
    #1;
    n_checks++;
    if (muldiv_done !== 1'b1) begin
      n_fail++;
      $display("FAIL protocol_done_t5: got %b want 1", muldiv_done);
    end
    issue = 1'b1;
    tick();
    issue = 1'b0;
    for (int k = 1; k <= LAT + 1; k++) begin
      #3;
      n_checks++;
      if ({muldiv_busy, muldiv_done, protocol_err} !== {1'(k <= LAT), 1'(k == LAT), 1'b1}) begin
        n_fail++;
        $display("FAIL reload t%0d busy/done/err: got %b want %b", k,
                 {muldiv_busy, muldiv_done, protocol_err}, {1'(k <= LAT), 1'(k == LAT), 1'b1});
      end
      tick();
    end
    apply_reset();
    #3;
    n_checks++;
    if (protocol_err !== 1'b0) begin
      n_fail++;
      $display("FAIL protocol_err_cleared: got %b want 0", protocol_err);
    end
  endtask

  task automatic test_reset_mid_busy();
    apply_reset();
    issue = 1'b1;
    tick();
    issue = 1'b0;
    hilo = 1'b1;
    tick();
    tick();
    #3;
    reset = 1'b1;
    model_clear();
    #1;
    n_checks++;
    if ({muldiv_busy, muldiv_done, pc_write, if_id_write, if_id_flush, id_ex_flush} !== 6'b001100) begin
      n_fail++;
      $display("FAIL async_reset_mid_busy: got %b want 001100",
               {muldiv_busy, muldiv_done, pc_write, if_id_write, if_id_flush, id_ex_flush});
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      #3;
      n_checks++;
      if ({muldiv_busy, muldiv_done} !== 2'b00) begin
        n_fail++;
        $display("FAIL reset_held_no_done %0d: got %b want 00", i, {muldiv_busy, muldiv_done});
      end
    end
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #3;
      n_checks++;
      if ({muldiv_busy, muldiv_done, pc_write} !== 3'b001) begin
        n_fail++;
        $display("FAIL abandoned_no_done %0d: got %b want 001", i, {muldiv_busy, muldiv_done, pc_write});
      end
      tick();
    end
    hilo = 1'b0;
  endtask

  task automatic test_perf();
    logic [31:0] want_s, want_f;
    apply_reset();
    rs = 1'b1;
    repeat (3) tick();
    rs = 1'b0;
    br = 1'b1;
    repeat (2) tick();
    br = 1'b0;
    tick();
`ifdef HAZARD_PERF_EN
    want_s = 32'd3;
    want_f = 32'd2;
`else
    want_s = 32'd0;
    want_f = 32'd0;
`endif
    #3;
    n_checks++;
    if ({stall_count, flush_count} !== {want_s, want_f}) begin
      n_fail++;
      $display("FAIL perf_counts: got %0d/%0d want %0d/%0d", stall_count, flush_count, want_s, want_f);
    end
  endtask

  task automatic test_random();
    logic [31:0] want_s, want_f;
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      rs    = ($urandom_range(0, 9) == 0);
      rt    = ($urandom_range(0, 9) == 0);
      br    = ($urandom_range(0, 4) == 0);
      hilo  = $urandom_range(0, 1) == 1;
      issue = ($urandom_range(0, 7) == 0);
      #3;
      n_checks++;
      if ({pc_write, if_id_write, if_id_flush, id_ex_flush} !== e_ctrl()) begin
        n_fail++;
        $display("FAIL rand_ctrl cycle %0d: got %b want %b", c,
                 {pc_write, if_id_write, if_id_flush, id_ex_flush}, e_ctrl());
      end
      n_checks++;
      if ({muldiv_busy, muldiv_done, protocol_err} !== {e_busy(), e_done(), m_err}) begin
        n_fail++;
        $display("FAIL rand_status cycle %0d: got %b want %b", c,
                 {muldiv_busy, muldiv_done, protocol_err}, {e_busy(), e_done(), m_err});
      end
`ifdef HAZARD_PERF_EN
      want_s = 32'(m_sc);
      want_f = 32'(m_fc);
`else
      want_s = 32'd0;
      want_f = 32'd0;
`endif
      n_checks++;
      if ({stall_count, flush_count} !== {want_s, want_f}) begin
        n_fail++;
        $display("FAIL rand_counts cycle %0d: got %0d/%0d want %0d/%0d", c,
                 stall_count, flush_count, want_s, want_f);
      end
      tick();
    end
    {rs, rt, br, hilo, issue} = '0;
  endtask

  initial begin
    test_reset();
    test_fwd_stall();
    test_branch();
    test_muldiv();
    test_protocol();
    test_reset_mid_busy();
    test_perf();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
